// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response codes, bridge FSM states and response merging
package axi_pkg;
    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_e;
    typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11} resp_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_B} wr_state_e;

    // Numeric order of the codes doubles as severity order.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: per-burst address/beat tracker; FIXED holds, INCR and WRAP step by 1<<size
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        len_in,
    input  logic [2:0]        size_in,
    input  logic [1:0]        burst_in,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [7:0] beat, len;
    logic [2:0] size;
    logic [1:0] burst;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr  <= '0;
            beat  <= '0;
            len   <= '0;
            size  <= '0;
            burst <= '0;
        end else if (load) begin
            addr  <= addr_in;
            beat  <= '0;
            len   <= len_in;
            size  <= size_in;
            burst <= burst_in;
        end else if (advance) begin
            addr <= (burst == BURST_FIXED) ? addr : addr + (ADDR_W'(1) << size);
            beat <= beat + 8'd1;
        end
    end

    assign last = (beat == len);
endmodule

// File: rtl/axi_burst_to_lite.sv
// axi_burst_to_lite: AXI4 burst slave to AXI4-Lite single-beat master bridge, independent read/write FSMs
module axi_burst_to_lite
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]                  m_axil_awprot,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]                  m_axil_arprot,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready
);
    rd_state_e rd_state, rd_next;
    wr_state_e wr_state, wr_next;
    logic [AXI_ID_WIDTH-1:0]   rid_q, bid_q;
    logic [2:0]                arprot_q, awprot_q;
    logic [1:0]                resp_acc;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic rd_last, wr_last, rd_load, rd_adv, wr_load, wr_adv;
    logic aw_done, w_done, last_err, aw_hs, w_hs;

    axi_burst_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH)) u_rd_gen (
        .aclk(aclk), .areset(areset), .load(rd_load), .advance(rd_adv),
        .addr_in(s_axi_araddr), .len_in(s_axi_arlen), .size_in(s_axi_arsize), .burst_in(s_axi_arburst),
        .addr(rd_addr), .last(rd_last)
    );

    axi_burst_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH)) u_wr_gen (
        .aclk(aclk), .areset(areset), .load(wr_load), .advance(wr_adv),
        .addr_in(s_axi_awaddr), .len_in(s_axi_awlen), .size_in(s_axi_awsize), .burst_in(s_axi_awburst),
        .addr(wr_addr), .last(wr_last)
    );

    assign m_axil_araddr = rd_addr;
    assign m_axil_arprot = arprot_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = m_axil_rdata;
    assign s_axi_rresp   = m_axil_rresp;
    assign s_axi_rlast   = rd_last;

    always_comb begin
        rd_next        = rd_state;
        s_axi_arready  = 1'b0;
        m_axil_arvalid = 1'b0;
        s_axi_rvalid   = 1'b0;
        m_axil_rready  = 1'b0;
        rd_load        = 1'b0;
        rd_adv         = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = !areset;
                rd_load       = s_axi_arvalid && !areset;
                rd_next       = rd_load ? R_ADDR : R_IDLE;
            end
            R_ADDR: begin
                m_axil_arvalid = 1'b1;
                rd_next        = m_axil_arready ? R_DATA : R_ADDR;
            end
            R_DATA: begin
                s_axi_rvalid  = m_axil_rvalid;
                m_axil_rready = s_axi_rready;
                if (m_axil_rvalid && s_axi_rready) begin
                    rd_next = rd_last ? R_IDLE : R_ADDR;
                    rd_adv  = !rd_last;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state <= R_IDLE;
            rid_q    <= '0;
            arprot_q <= '0;
        end else begin
            rd_state <= rd_next;
            if (rd_load) begin
                rid_q    <= s_axi_arid;
                arprot_q <= s_axi_arprot;
            end
        end
    end

    // Handshakes derived from state/flags directly so the FSM block never reads its own outputs.
    assign aw_hs = (wr_state == W_XFER) && !aw_done && m_axil_awready;
    assign w_hs  = (wr_state == W_XFER) && !w_done && s_axi_wvalid && m_axil_wready;

    assign m_axil_awaddr = wr_addr;
    assign m_axil_awprot = awprot_q;
    assign m_axil_wdata  = s_axi_wdata;
    assign m_axil_wstrb  = s_axi_wstrb;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = last_err ? RESP_SLVERR : resp_acc;

    always_comb begin
        wr_next        = wr_state;
        s_axi_awready  = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        s_axi_wready   = 1'b0;
        m_axil_bready  = 1'b0;
        s_axi_bvalid   = 1'b0;
        wr_load        = 1'b0;
        wr_adv         = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_axi_awready = !areset;
                wr_load       = s_axi_awvalid && !areset;
                wr_next       = wr_load ? W_XFER : W_IDLE;
            end
            W_XFER: begin
                m_axil_awvalid = !aw_done;
                m_axil_wvalid  = s_axi_wvalid && !w_done;
                s_axi_wready   = m_axil_wready && !w_done;
                wr_next        = ((aw_done || aw_hs) && (w_done || w_hs)) ? W_RESP : W_XFER;
            end
            W_RESP: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    wr_next = wr_last ? W_B : W_XFER;
                    wr_adv  = !wr_last;
                end
            end
            W_B: begin
                s_axi_bvalid = 1'b1;
                wr_next      = s_axi_bready ? W_IDLE : W_B;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state <= W_IDLE;
            bid_q    <= '0;
            awprot_q <= '0;
            resp_acc <= RESP_OKAY;
            last_err <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            aw_done  <= (wr_state == W_XFER) && (aw_done || aw_hs);
            w_done   <= (wr_state == W_XFER) && (w_done || w_hs);
            if (wr_load) begin
                bid_q    <= s_axi_awid;
                awprot_q <= s_axi_awprot;
                resp_acc <= RESP_OKAY;
                last_err <= 1'b0;
            end
            if (w_hs && (s_axi_wlast != wr_last))
                last_err <= 1'b1;
            if ((wr_state == W_RESP) && m_axil_bvalid)
                resp_acc <= resp_max(resp_acc, m_axil_bresp);
        end
    end
endmodule

// File: tb/tb_axi_burst_to_lite.sv
// tb_axi_burst_to_lite: directed bench with a behavioural AXI-Lite slave behind the bridge
module tb_axi_burst_to_lite;
    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [11:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [11:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;
    logic [31:0] m_axil_wdata, m_axil_rdata;
    logic [3:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp, m_axil_rresp;

    int tests = 0, fails = 0;

    axi_burst_to_lite dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr),
        .m_axil_arprot(m_axil_arprot), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(m_axil_rready)
    );

    always #5 aclk = ~aclk;

    // Lite slave: always ready for AW/W, one B per AW+W pair, one outstanding read returning D0000<addr>.
    int aw_cnt, w_cnt, b_cnt, err_idx = -1;
    logic [11:0] aw_log[$], ar_log[$];
    logic [31:0] w_log[$];
    assign m_axil_awready = 1'b1;
    assign m_axil_wready  = 1'b1;
    assign m_axil_arready = !m_axil_rvalid;
    assign m_axil_bvalid  = (b_cnt < aw_cnt) && (b_cnt < w_cnt);
    assign m_axil_bresp   = (b_cnt == err_idx) ? 2'b10 : 2'b00;
    assign m_axil_rresp   = 2'b00;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_cnt <= 0;
            w_cnt <= 0;
            b_cnt <= 0;
            m_axil_rvalid <= 1'b0;
            m_axil_rdata <= '0;
        end else begin
            if (m_axil_awvalid && m_axil_awready) begin aw_cnt <= aw_cnt + 1; aw_log.push_back(m_axil_awaddr); end
            if (m_axil_wvalid && m_axil_wready) begin w_cnt <= w_cnt + 1; w_log.push_back(m_axil_wdata); end
            if (m_axil_bvalid && m_axil_bready) b_cnt <= b_cnt + 1;
            if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
            if (m_axil_arvalid && m_axil_arready) begin
                m_axil_rvalid <= 1'b1;
                m_axil_rdata <= {20'hD0000, m_axil_araddr};
                ar_log.push_back(m_axil_araddr);
            end
        end
    end

    logic [31:0] rd_data[16];
    logic        rd_last[16];
    logic [3:0]  rd_id[16];
    int          rd_n, rready_leak, extra_r, got_b, b_at, w_sent;
    logic        first_arvalid;
    logic [11:0] first_araddr;
    logic [3:0]  got_bid;
    logic [1:0]  got_bresp;

    task automatic do_read(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len, input int stall_at);
        int stall_left = 10;
        ar_log.delete();
        rd_n = 0; rready_leak = 0; extra_r = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'd2;
        s_axi_arburst = 2'b01; s_axi_arprot = 3'd0; s_axi_arvalid = 1'b1;
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        first_arvalid = m_axil_arvalid;
        first_araddr = m_axil_araddr;
        for (int c = 0; c < 300 && rd_n <= int'(len); c++) begin
            s_axi_rready = !(rd_n == stall_at && stall_left > 0);
            if (!s_axi_rready) begin
                stall_left--;
                if (m_axil_rready) rready_leak++;
            end
            if (s_axi_rvalid && s_axi_rready) begin
                rd_data[rd_n] = s_axi_rdata; rd_last[rd_n] = s_axi_rlast; rd_id[rd_n] = s_axi_rid;
                rd_n++;
            end
            @(negedge aclk);
        end
        s_axi_rready = 1'b0;
        repeat (3) begin
            if (s_axi_rvalid) extra_r++;
            @(negedge aclk);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input int stall);
        int stall_left = stall;
        aw_log.delete(); w_log.delete();
        got_b = 0; w_sent = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = 3'd2;
        s_axi_awburst = burst; s_axi_awprot = 3'd0; s_axi_awvalid = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        for (int c = 0; c < 300 && got_b == 0; c++) begin
            s_axi_wvalid = w_sent < nbeats;
            s_axi_wdata = 32'hCAFE_0000 + w_sent;
            s_axi_wlast = (w_sent == nbeats - 1);
            s_axi_bready = (stall_left == 0);
            if (s_axi_bvalid && !s_axi_bready) stall_left--;
            if (s_axi_wvalid && s_axi_wready) w_sent++;
            if (s_axi_bvalid && s_axi_bready) begin
                got_b++; got_bid = s_axi_bid; got_bresp = s_axi_bresp; b_at = b_cnt;
            end
            @(negedge aclk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        repeat (3) begin
            if (s_axi_bvalid) got_b++;
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        @(negedge aclk);
        tests++;
        if ({s_axi_awready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid} !== 7'b0) begin
            fails++; $display("FAIL reset_outputs: got %b expected 0000000",
                {s_axi_awready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid});
        end
        areset = 1'b0;
        @(negedge aclk);
        tests++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            fails++; $display("FAIL reset_ready: got %b expected 11", {s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_incr_read();
        do_read(4'd5, 12'h100, 8'd3, -1);
        tests++;
        if (!(first_arvalid === 1'b1 && first_araddr === 12'h100)) begin
            fails++; $display("FAIL incr_first_ar: got valid %b addr %h expected 1 100", first_arvalid, first_araddr);
        end
        tests++;
        if (rd_n !== 4 || ar_log.size() !== 4 || extra_r !== 0) begin
            fails++; $display("FAIL incr_counts: got beats %0d ar %0d extra %0d expected 4 4 0", rd_n, ar_log.size(), extra_r);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (ar_log[i] !== 12'h100 + 12'(4 * i) || rd_data[i] !== {20'hD0000, 12'h100 + 12'(4 * i)}
                    || rd_last[i] !== (i == 3) || rd_id[i] !== 4'd5) begin
                    fails++; $display("FAIL incr_beat%0d: got ar %h data %h last %b id %h expected %h %h %b 5", i,
                        ar_log[i], rd_data[i], rd_last[i], rd_id[i], 12'h100 + 12'(4 * i),
                        {20'hD0000, 12'h100 + 12'(4 * i)}, i == 3);
                end
            end
        end
    endtask

    task automatic test_fixed_write();
        do_write(4'd9, 12'h040, 8'd2, 2'b00, 3, 0);
        tests++;
        if (got_b !== 1 || got_bid !== 4'd9 || got_bresp !== 2'b00) begin
            fails++; $display("FAIL fixed_b: got count %0d id %h resp %b expected 1 9 00", got_b, got_bid, got_bresp);
        end
        tests++;
        if (aw_log.size() !== 3 || w_log.size() !== 3) begin
            fails++; $display("FAIL fixed_counts: got aw %0d w %0d expected 3 3", aw_log.size(), w_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (aw_log[i] !== 12'h040 || w_log[i] !== 32'hCAFE_0000 + 32'(i)) begin
                    fails++; $display("FAIL fixed_beat%0d: got addr %h data %h expected 040 %h", i, aw_log[i], w_log[i], 32'hCAFE_0000 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_write_slverr();
        int start = b_cnt;
        err_idx = start + 1;
        do_write(4'd3, 12'h080, 8'd1, 2'b01, 2, 0);
        err_idx = -1;
        tests++;
        if (got_b !== 1 || got_bid !== 4'd3 || got_bresp !== 2'b10 || b_at !== start + 2) begin
            fails++; $display("FAIL slverr_b: got count %0d id %h resp %b lite_b %0d expected 1 3 10 %0d",
                got_b, got_bid, got_bresp, b_at, start + 2);
        end
        tests++;
        if (aw_log.size() !== 2 || aw_log[0] !== 12'h080 || aw_log[1] !== 12'h084) begin
            fails++; $display("FAIL slverr_addr: got %0d entries first %h expected 2 080 084", aw_log.size(), aw_log[0]);
        end
    endtask

    task automatic test_addr_wrap();
        do_read(4'd1, 12'hFFC, 8'd1, -1);
        tests++;
        if (ar_log.size() !== 2 || ar_log[0] !== 12'hFFC || ar_log[1] !== 12'h000) begin
            fails++; $display("FAIL wrap_addr: got %0d entries %h expected 2 FFC 000", ar_log.size(), ar_log[0]);
        end
        tests++;
        if (rd_n !== 2 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1 || rd_data[1] !== 32'hD000_0000) begin
            fails++; $display("FAIL wrap_data: got beats %0d last %b%b data %h expected 2 01 D0000000",
                rd_n, rd_last[0], rd_last[1], rd_data[1]);
        end
    endtask

    task automatic test_stall();
        do_read(4'd7, 12'h200, 8'd3, 2);
        tests++;
        if (rd_n !== 4 || rready_leak !== 0 || extra_r !== 0) begin
            fails++; $display("FAIL stall_read: got beats %0d leak %0d extra %0d expected 4 0 0", rd_n, rready_leak, extra_r);
        end
        tests++;
        if (rd_data[0] !== 32'hD000_0200 || rd_data[1] !== 32'hD000_0204 || rd_data[2] !== 32'hD000_0208
            || rd_data[3] !== 32'hD000_020C || rd_last[3] !== 1'b1 || rd_last[2] !== 1'b0) begin
            fails++; $display("FAIL stall_order: got %h %h %h %h expected D0000200 D0000204 D0000208 D000020C",
                rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
        do_write(4'd4, 12'h300, 8'd0, 2'b01, 1, 10);
        tests++;
        if (got_b !== 1 || got_bid !== 4'd4 || got_bresp !== 2'b00 || aw_log.size() !== 1) begin
            fails++; $display("FAIL stall_write: got count %0d id %h resp %b aw %0d expected 1 4 00 1",
                got_b, got_bid, got_bresp, aw_log.size());
        end
    endtask

    task automatic test_reset_mid_write();
        int seen_b = 0;
        s_axi_awid = 4'd6; s_axi_awaddr = 12'h400; s_axi_awlen = 8'd3; s_axi_awsize = 3'd2;
        s_axi_awburst = 2'b01; s_axi_awprot = 3'd0; s_axi_awvalid = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        w_sent = 0;
        s_axi_bready = 1'b1;
        for (int c = 0; c < 100 && w_sent < 2; c++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = 32'hBEEF_0000 + w_sent; s_axi_wlast = 1'b0;
            if (s_axi_wready) w_sent++;
            @(negedge aclk);
        end
        areset = 1'b1;
        s_axi_wvalid = 1'b0;
        @(negedge aclk);
        tests++;
        if ({s_axi_bvalid, s_axi_rvalid, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, s_axi_awready} !== 7'b0) begin
            fails++; $display("FAIL midreset_valids: got %b expected 0000000",
                {s_axi_bvalid, s_axi_rvalid, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, s_axi_awready});
        end
        areset = 1'b0;
        repeat (4) begin
            if (s_axi_bvalid) seen_b++;
            @(negedge aclk);
        end
        s_axi_bready = 1'b0;
        tests++;
        if (seen_b !== 0 || w_sent !== 2) begin
            fails++; $display("FAIL midreset_noB: got B cycles %0d w beats %0d expected 0 2", seen_b, w_sent);
        end
        do_write(4'd2, 12'h500, 8'd1, 2'b01, 2, 0);
        tests++;
        if (got_b !== 1 || got_bid !== 4'd2 || got_bresp !== 2'b00 || aw_log.size() !== 2 || aw_log[1] !== 12'h504) begin
            fails++; $display("FAIL midreset_after: got count %0d id %h resp %b aw %0d last %h expected 1 2 00 2 504",
                got_b, got_bid, got_bresp, aw_log.size(), aw_log[aw_log.size() - 1]);
        end
    endtask

    initial begin
        areset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awprot = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        test_reset();
        test_incr_read();
        test_fixed_write();
        test_write_slverr();
        test_addr_wrap();
        test_stall();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
